// File: rtl/grid_pkg.sv
// rtl/grid_pkg.sv - tile codes, tile helpers and FSM state encoding for grid_interact
package grid_pkg;

  localparam int unsigned T_FLOOR    = 0;
  localparam int unsigned T_WALL     = 1;
  localparam int unsigned T_BOX      = 2;
  localparam int unsigned T_GOAL     = 3;
  localparam int unsigned T_BOX_GOAL = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ARB,
    ST_RD1,
    ST_EV1,
    ST_RD2,
    ST_EV2,
    ST_WR1,
    ST_WR2,
    ST_RESP
  } state_t;

  // An agent may stand on floor or goal; every other code blocks it.
  function automatic logic is_passable(input int unsigned t);
    return (t == T_FLOOR) || (t == T_GOAL);
  endfunction

  function automatic logic is_box(input int unsigned t);
    return (t == T_BOX) || (t == T_BOX_GOAL);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with one-hot grant and advancing pointer
module rr_arbiter #(
  parameter int N = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ib;
  int            idx;

  // Pick the first requester at or after the pointer, wrapping once around.
  always_comb begin
    grant   = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    idx     = 0;
    ib      = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(ptr) + i;
      if (idx >= N) idx = idx - N;
      ib = PW'(idx);
      if (!gnt_any && req[ib]) begin
        gnt_any   = 1'b1;
        grant[ib] = 1'b1;
        gnt_idx   = ib;
      end
    end
  end

  // Park the pointer one past the winner so the winner is searched last next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv && gnt_any) begin
      ptr <= (int'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/grid_interact.sv
// rtl/grid_interact.sv - multi-agent move arbiter resolving moves and box pushes against map RAM
module grid_interact
  import grid_pkg::*;
#(
  parameter int N_AGENTS    = 2,
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 12,
  parameter int XW          = 4,
  parameter int TILE_W      = 4,
  parameter int AW          = 8,
  parameter int PUSH_EN     = 1,
  parameter int AGENT_BLOCK = 1
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic [N_AGENTS-1:0]    ask_move,
  input  logic [N_AGENTS*XW-1:0] ask_x,
  input  logic [N_AGENTS*XW-1:0] ask_y,
  input  logic [N_AGENTS*XW-1:0] cur_x,
  input  logic [N_AGENTS*XW-1:0] cur_y,
  output logic [N_AGENTS-1:0]    accept_move,
  output logic [N_AGENTS-1:0]    reject_move,
  output logic [XW-1:0]          goto_x,
  output logic [XW-1:0]          goto_y,
  output logic [AW-1:0]          map_raddr,
  input  logic [TILE_W-1:0]      map_rdata,
  output logic                   map_we,
  output logic [AW-1:0]          map_waddr,
  output logic [TILE_W-1:0]      map_wdata
);

  localparam int PW = (N_AGENTS > 1) ? $clog2(N_AGENTS) : 1;
  localparam logic [XW:0] D_POS = (XW+1)'(1);
  localparam logic [XW:0] D_NEG = '1;

  state_t              state, nxt;
  logic [N_AGENTS-1:0] req_m, grant, gnt_oh, hold_mask;
  logic [PW-1:0]       gnt_idx;
  logic                gnt_any;
  logic [XW-1:0]       tx, ty, bxr, byr;
  logic [XW:0]         dx, dy;
  logic [TILE_W-1:0]   tgt_tile, bey_tile;
  logic                acc, acc_n;
  logic [XW-1:0]       sel_ax, sel_ay, sel_cx, sel_cy;
  logic [XW:0]         sel_dx, sel_dy, bx, by;
  logic                geo_ok, tgt_agent, bey_oob, bey_agent;

  function automatic logic [AW-1:0] addr_of(input logic [XW-1:0] x, input logic [XW-1:0] y);
    return AW'(int'(y) * GRID_W + int'(x));
  endfunction

  // The channel just answered is masked for one IDLE cycle so its held request is not re-served.
  assign req_m = ask_move & ~hold_mask;

  rr_arbiter #(.N(N_AGENTS)) u_arb (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .req     (req_m),
    .adv     (state == ST_ARB),
    .grant   (grant),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  // Decode the granted request and check step size, bounds and agent collisions.
  always_comb begin
    sel_ax    = ask_x[gnt_idx*XW +: XW];
    sel_ay    = ask_y[gnt_idx*XW +: XW];
    sel_cx    = cur_x[gnt_idx*XW +: XW];
    sel_cy    = cur_y[gnt_idx*XW +: XW];
    sel_dx    = {1'b0, sel_ax} - {1'b0, sel_cx};
    sel_dy    = {1'b0, sel_ay} - {1'b0, sel_cy};
    geo_ok    = ((sel_dx == '0) && ((sel_dy == D_POS) || (sel_dy == D_NEG))) ||
                ((sel_dy == '0) && ((sel_dx == D_POS) || (sel_dx == D_NEG)));
    if ((int'(sel_ax) >= GRID_W) || (int'(sel_ay) >= GRID_H)) geo_ok = 1'b0;
    tgt_agent = 1'b0;
    for (int j = 0; j < N_AGENTS; j++) begin
      if ((j != int'(gnt_idx)) && (cur_x[j*XW +: XW] == sel_ax) && (cur_y[j*XW +: XW] == sel_ay))
        tgt_agent = 1'b1;
    end
    if ((AGENT_BLOCK != 0) && tgt_agent) geo_ok = 1'b0;
  end

  // Square beyond the target along the step; the extra top bit flags negative or overflowed coordinates.
  always_comb begin
    bx        = {1'b0, tx} + dx;
    by        = {1'b0, ty} + dy;
    bey_oob   = bx[XW] || by[XW] ||
                (int'(bx[XW-1:0]) >= GRID_W) || (int'(by[XW-1:0]) >= GRID_H);
    bey_agent = 1'b0;
    for (int j = 0; j < N_AGENTS; j++) begin
      if ((cur_x[j*XW +: XW] == bx[XW-1:0]) && (cur_y[j*XW +: XW] == by[XW-1:0]))
        bey_agent = 1'b1;
    end
  end

  // Next-state decision; acc_n carries the verdict into RESP.
  always_comb begin
    nxt   = state;
    acc_n = 1'b0;
    case (state)
      ST_IDLE: if (|req_m) nxt = ST_ARB;
      ST_ARB: begin
        if (!gnt_any)    nxt = ST_IDLE;
        else if (geo_ok) nxt = ST_RD1;
        else             nxt = ST_RESP;
      end
      ST_RD1: nxt = ST_EV1;
      ST_EV1: begin
        if (is_passable(32'(map_rdata))) begin
          nxt   = ST_RESP;
          acc_n = 1'b1;
        end else if ((PUSH_EN != 0) && is_box(32'(map_rdata)) && !bey_oob &&
                     !((AGENT_BLOCK != 0) && bey_agent)) begin
          nxt = ST_RD2;
        end else begin
          nxt = ST_RESP;
        end
      end
      ST_RD2: nxt = ST_EV2;
      ST_EV2: nxt = is_passable(32'(map_rdata)) ? ST_WR1 : ST_RESP;
      ST_WR1: nxt = ST_WR2;
      ST_WR2: begin
        nxt   = ST_RESP;
        acc_n = 1'b1;
      end
      ST_RESP: nxt = ST_IDLE;
      default: nxt = ST_IDLE;
    endcase
  end

  // Outputs decode from state so a reset clears them immediately.
  always_comb begin
    accept_move = '0;
    reject_move = '0;
    goto_x      = '0;
    goto_y      = '0;
    map_we      = 1'b0;
    map_waddr   = '0;
    map_wdata   = '0;
    case (state)
      ST_WR1: begin
        map_we    = 1'b1;
        map_waddr = addr_of(bxr, byr);
        map_wdata = (32'(bey_tile) == T_GOAL) ? TILE_W'(T_BOX_GOAL) : TILE_W'(T_BOX);
      end
      ST_WR2: begin
        map_we    = 1'b1;
        map_waddr = addr_of(tx, ty);
        map_wdata = (32'(tgt_tile) == T_BOX_GOAL) ? TILE_W'(T_GOAL) : TILE_W'(T_FLOOR);
      end
      ST_RESP: begin
        if (acc) begin
          accept_move = gnt_oh;
          goto_x      = tx;
          goto_y      = ty;
        end else begin
          reject_move = gnt_oh;
        end
      end
      default: ;
    endcase
  end

  // State register.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= ST_IDLE;
    else         state <= nxt;
  end

  // Transaction context: granted channel, target, step, sampled tiles and read address.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gnt_oh    <= '0;
      hold_mask <= '0;
      tx        <= '0;
      ty        <= '0;
      dx        <= '0;
      dy        <= '0;
      bxr       <= '0;
      byr       <= '0;
      tgt_tile  <= '0;
      bey_tile  <= '0;
      acc       <= 1'b0;
      map_raddr <= '0;
    end else begin
      hold_mask <= '0;
      case (state)
        ST_ARB: begin
          gnt_oh <= grant;
          tx     <= sel_ax;
          ty     <= sel_ay;
          dx     <= sel_dx;
          dy     <= sel_dy;
          if (nxt == ST_RD1) map_raddr <= addr_of(sel_ax, sel_ay);
        end
        ST_EV1: begin
          tgt_tile <= map_rdata;
          bxr      <= bx[XW-1:0];
          byr      <= by[XW-1:0];
          if (nxt == ST_RD2) map_raddr <= addr_of(bx[XW-1:0], by[XW-1:0]);
        end
        ST_EV2:  bey_tile  <= map_rdata;
        ST_RESP: hold_mask <= gnt_oh;
        default: ;
      endcase
      if (nxt == ST_RESP) acc <= acc_n;
    end
  end

endmodule

// File: tb/tb_grid_interact.sv
// tb/tb_grid_interact.sv - directed table-driven bench for grid_interact
module tb_grid_interact;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b0;
  logic [1:0] ask0, ask1;
  logic [7:0] ask_x, ask_y, cur_x, cur_y;
  logic [1:0] acc0, rej0, acc1, rej1;
  logic [3:0] gx0, gy0, gx1, gy1;
  logic [7:0] raddr0, raddr1, waddr0, waddr1;
  logic [3:0] rdata0, rdata1, wdata0, wdata1;
  logic       we0, we1;
  logic [3:0] mem [0:255];
  logic       tb_clr, tb_poke;
  logic [7:0] tb_addr;
  logic [3:0] tb_data;
  int         n_cmp = 0;
  int         n_bad = 0;

  typedef struct {
    int dut, ch;
    int c0x, c0y, c1x, c1y, ax, ay;
    int tt, bx, by, bt;
    int acc, lat, nw, w1d, w2d;
  } vec_t;

  vec_t vecs [17];

  grid_interact dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ask_move(ask0),
    .ask_x(ask_x), .ask_y(ask_y), .cur_x(cur_x), .cur_y(cur_y),
    .accept_move(acc0), .reject_move(rej0), .goto_x(gx0), .goto_y(gy0),
    .map_raddr(raddr0), .map_rdata(rdata0), .map_we(we0),
    .map_waddr(waddr0), .map_wdata(wdata0)
  );

  grid_interact #(.PUSH_EN(0)) dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .ask_move(ask1),
    .ask_x(ask_x), .ask_y(ask_y), .cur_x(cur_x), .cur_y(cur_y),
    .accept_move(acc1), .reject_move(rej1), .goto_x(gx1), .goto_y(gy1),
    .map_raddr(raddr1), .map_rdata(rdata1), .map_we(we1),
    .map_waddr(waddr1), .map_wdata(wdata1)
  );

  always #5 sys_clk = ~sys_clk;

  // Map RAM model: one-cycle read latency, writes from dut0 or bench setup.
  always @(posedge sys_clk) begin
    rdata0 <= mem[raddr0];
    rdata1 <= mem[raddr1];
    if (tb_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 4'd0;
    end else if (we0) begin
      mem[waddr0] <= wdata0;
    end else if (tb_poke) begin
      mem[tb_addr] <= tb_data;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_map();
    @(negedge sys_clk); tb_clr = 1'b1;
    @(negedge sys_clk); tb_clr = 1'b0;
  endtask

  task automatic poke(input int x, input int y, input int t);
    tb_poke = 1'b1; tb_addr = 8'(y * 16 + x); tb_data = 4'(t);
    @(negedge sys_clk); tb_poke = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int k);
    int  lat, nw, a_s, r_s, gx_s, gy_s;
    int  wa [2];
    int  wd [2];
    bit  seen;
    clear_map();
    poke(v.ax, v.ay, v.tt);
    poke(v.bx, v.by, v.bt);
    cur_x = {4'(v.c1x), 4'(v.c0x)};
    cur_y = {4'(v.c1y), 4'(v.c0y)};
    ask_x = (v.ch == 1) ? {4'(v.ax), 4'd0} : {4'd0, 4'(v.ax)};
    ask_y = (v.ch == 1) ? {4'(v.ay), 4'd0} : {4'd0, 4'(v.ay)};
    if (v.dut == 0) ask0 = 2'b01 << v.ch;
    else            ask1 = 2'b01 << v.ch;
    lat = 1; seen = 0; nw = 0;
    a_s = 0; r_s = 0; gx_s = 0; gy_s = 0;
    wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    while (!seen && lat < 20) begin
      @(posedge sys_clk); lat++;
      @(negedge sys_clk);
      if ((v.dut == 0) ? we0 : we1) begin
        if (nw < 2) begin
          wa[nw] = (v.dut == 0) ? int'(waddr0) : int'(waddr1);
          wd[nw] = (v.dut == 0) ? int'(wdata0) : int'(wdata1);
        end
        nw++;
      end
      a_s = (v.dut == 0) ? int'(acc0) : int'(acc1);
      r_s = (v.dut == 0) ? int'(rej0) : int'(rej1);
      if (a_s != 0 || r_s != 0) begin
        seen = 1;
        gx_s = (v.dut == 0) ? int'(gx0) : int'(gx1);
        gy_s = (v.dut == 0) ? int'(gy0) : int'(gy1);
      end
    end
    ask0 = 2'b00; ask1 = 2'b00;
    chk($sformatf("v%0d pulse_seen", k), int'(seen), 1);
    if (seen) begin
      chk($sformatf("v%0d latency", k), lat, v.lat);
      chk($sformatf("v%0d accept", k), a_s, (v.acc != 0) ? (1 << v.ch) : 0);
      chk($sformatf("v%0d reject", k), r_s, (v.acc != 0) ? 0 : (1 << v.ch));
      if (v.acc != 0) begin
        chk($sformatf("v%0d goto_x", k), gx_s, v.ax);
        chk($sformatf("v%0d goto_y", k), gy_s, v.ay);
      end
    end
    chk($sformatf("v%0d writes", k), nw, v.nw);
    if (v.nw == 2) begin
      chk($sformatf("v%0d w1_addr", k), wa[0], v.by * 16 + v.bx);
      chk($sformatf("v%0d w1_data", k), wd[0], v.w1d);
      chk($sformatf("v%0d w2_addr", k), wa[1], v.ay * 16 + v.ax);
      chk($sformatf("v%0d w2_data", k), wd[1], v.w2d);
    end
    @(posedge sys_clk); @(negedge sys_clk);
    chk($sformatf("v%0d one_cycle", k), int'(acc0 | rej0 | acc1 | rej1), 0);
  endtask

  initial begin
    int  cnt;
    bit  seen;

    //           dut ch c0x c0y c1x c1y ax ay  tt bx by bt acc lat nw w1 w2
    vecs[0]  = '{0, 0,  2,  2, 10, 10, 3,  2, 0, 4, 2, 0, 1, 5, 0, 0, 0};
    vecs[1]  = '{0, 0,  2,  2, 10, 10, 4,  2, 0, 0, 0, 0, 0, 3, 0, 0, 0};
    vecs[2]  = '{0, 0,  2,  2, 10, 10, 3,  2, 1, 0, 0, 0, 0, 5, 0, 0, 0};
    vecs[3]  = '{0, 0,  0,  0, 10, 10, 0, 15, 0, 0, 0, 0, 0, 3, 0, 0, 0};
    vecs[4]  = '{0, 0,  2,  2, 10, 10, 3,  2, 2, 4, 2, 0, 1, 9, 2, 2, 0};
    vecs[5]  = '{0, 0,  2,  2, 10, 10, 3,  2, 2, 4, 2, 3, 1, 9, 2, 4, 0};
    vecs[6]  = '{0, 0,  2,  2, 10, 10, 3,  2, 4, 4, 2, 0, 1, 9, 2, 2, 3};
    vecs[7]  = '{0, 0,  2,  2, 10, 10, 3,  2, 2, 4, 2, 1, 0, 7, 0, 0, 0};
    vecs[8]  = '{0, 0,  2,  2, 10, 10, 3,  2, 3, 0, 0, 0, 1, 5, 0, 0, 0};
    vecs[9]  = '{0, 0,  2,  2, 10, 10, 3,  2, 7, 0, 0, 0, 0, 5, 0, 0, 0};
    vecs[10] = '{0, 1,  2,  2,  3,  2, 2,  2, 0, 0, 0, 0, 0, 3, 0, 0, 0};
    vecs[11] = '{0, 0, 14,  5, 10, 10, 15, 5, 2, 0, 0, 0, 0, 5, 0, 0, 0};
    vecs[12] = '{0, 0,  2,  2,  4,  2, 3,  2, 2, 0, 0, 0, 0, 5, 0, 0, 0};
    vecs[13] = '{0, 0,  1,  1, 10, 10, 1,  0, 2, 0, 0, 0, 0, 5, 0, 0, 0};
    vecs[14] = '{0, 0, 15, 10,  0,  0, 15, 11, 0, 0, 0, 0, 1, 5, 0, 0, 0};
    vecs[15] = '{0, 0, 15, 11,  0,  0, 15, 12, 0, 0, 0, 0, 0, 3, 0, 0, 0};
    vecs[16] = '{1, 0,  2,  2, 10, 10, 3,  2, 2, 4, 2, 0, 0, 5, 0, 0, 0};

    ask0 = '0; ask1 = '0; ask_x = '0; ask_y = '0; cur_x = '0; cur_y = '0;
    tb_clr = 1'b0; tb_poke = 1'b0; tb_addr = '0; tb_data = '0;
    #1 sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    chk("reset pulses", int'(acc0 | rej0), 0);
    chk("reset map_we", int'(we0), 0);
    chk("reset map_raddr", int'(raddr0), 0);
    chk("reset goto", int'({gx0, gy0}), 0);
    sys_rst = 1'b0;

    // Simultaneous requests straight after reset: channel 0 first, then 1.
    clear_map();
    cur_x = {4'd5, 4'd2}; cur_y = {4'd5, 4'd2};
    ask_x = {4'd6, 4'd3}; ask_y = {4'd5, 4'd2};
    ask0 = 2'b11;
    cnt = 1;
    while ((acc0 | rej0) == 2'b00 && cnt < 20) begin
      @(posedge sys_clk); cnt++; @(negedge sys_clk);
    end
    chk("rr first accept", int'(acc0), 1);
    chk("rr first latency", cnt, 5);
    chk("rr first goto", int'({gx0, gy0}), 8'h32);
    ask0 = 2'b10;
    cnt = 0;
    do begin
      @(posedge sys_clk); cnt++; @(negedge sys_clk);
    end while ((acc0 | rej0) == 2'b00 && cnt < 20);
    chk("rr second accept", int'(acc0), 2);
    chk("rr second gap", cnt, 5);
    chk("rr second goto", int'({gx0, gy0}), 8'h65);
    ask0 = 2'b00;
    @(negedge sys_clk);

    for (int k = 0; k < 17; k++) run_vec(vecs[k], k);

    // Reset asserted while the first push write is on the bus.
    clear_map();
    poke(3, 2, 2);
    cur_x = {4'd10, 4'd2}; cur_y = {4'd10, 4'd2};
    ask_x = {4'd0, 4'd3};  ask_y = {4'd0, 4'd2};
    ask0 = 2'b01;
    seen = 0; cnt = 0;
    while (!seen && cnt < 20) begin
      @(negedge sys_clk); cnt++;
      if (we0) seen = 1;
    end
    chk("rst_wr1 reached", int'(seen), 1);
    chk("rst_wr1 is beyond write", int'({waddr0, wdata0}), (36 << 4) | 2);
    sys_rst = 1'b1;
    #1;
    chk("rst_wr1 map_we", int'(we0), 0);
    chk("rst_wr1 write bus", int'({waddr0, wdata0}), 0);
    chk("rst_wr1 map_raddr", int'(raddr0), 0);
    chk("rst_wr1 pulses", int'(acc0 | rej0), 0);
    chk("rst_wr1 goto", int'({gx0, gy0}), 0);
    ask0 = 2'b00;
    @(negedge sys_clk);
    sys_rst = 1'b0;
    repeat (2) @(negedge sys_clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/grid_interact.md
# grid_interact

Parametrised successor to the single-player move arbiter. Accepts move requests from `N_AGENTS` movers on a `GRID_W` x `GRID_H` tile map and resolves each request against map RAM: walls, bounds, other agents and, optionally, box pushing. Pushes are written back into the map. Sits between the per-agent move FSMs and the map RAM, with one request in flight at a time.

## Interface
- `N_AGENTS`, default 2: number of request channels, 1..8.
- `GRID_W`, default 16: map width in tiles.
- `GRID_H`, default 12: map height in tiles.
- `XW`, default 4: coordinate width; must satisfy 2^XW >= max(GRID_W, GRID_H).
- `TILE_W`, default 4: tile code width.
- `AW`, default 8: map address width; addr = y*GRID_W + x.
- `PUSH_EN`, default 1: enable box pushing. When 0, box tiles are treated as walls.
- `AGENT_BLOCK`, default 1: reject moves onto another agent's current tile.
- `sys_clk` in 1: the single clock; all logic on the rising edge.
- `sys_rst` in 1: asynchronous, active-high reset.
- `ask_move` in N_AGENTS: per-channel request, held high until acknowledged.
- `ask_x`, `ask_y` in N_AGENTS*XW: requested target per channel, packed with channel i at [i*XW +: XW].
- `cur_x`, `cur_y` in N_AGENTS*XW: current position per channel.
- `accept_move` out N_AGENTS: one-cycle accept pulse.
- `reject_move` out N_AGENTS: one-cycle reject pulse.
- `goto_x`, `goto_y` out XW: granted target, valid while any `accept_move` bit is high.
- `map_raddr` out AW: map read address.
- `map_rdata` in TILE_W: read data, valid exactly one cycle after `map_raddr` is presented.
- `map_we` out 1: map write strobe.
- `map_waddr` out AW: map write address.
- `map_wdata` out TILE_W: map write data.

## Operation
- Tile codes: FLOOR=0, WALL=1, BOX=2, GOAL=3, BOX_GOAL=4. Any other code is treated as WALL.
- Passable tiles are FLOOR and GOAL. Box tiles are BOX and BOX_GOAL.
- FSM states: IDLE, ARB, RD1, EV1, RD2, EV2, WR1, WR2, RESP.
- IDLE: if any `ask_move` bit is set, go to ARB.
- ARB: round-robin grant starting one past the last granted channel (after reset, search starts at channel 0). Latch ask, cur and the step d = ask - cur.
- ARB geometry check. Reject, going straight to RESP, if any of:
  - |dx|+|dy| != 1;
  - target is out of bounds (x >= GRID_W or y >= GRID_H);
  - `AGENT_BLOCK`=1 and the target equals `cur` of any other channel.
  - Otherwise go to RD1.
- RD1: drive `map_raddr` = target address.
- EV1, on the sampled tile:
  - passable: accept;
  - WALL: reject;
  - box with `PUSH_EN`=0: reject;
  - box with `PUSH_EN`=1: compute beyond = target + d. Reject if beyond is out of bounds, or if `AGENT_BLOCK`=1 and beyond holds any agent. Otherwise go to RD2.
- RD2: drive `map_raddr` = beyond address.
- EV2: if the beyond tile is passable, go to WR1; otherwise reject.
- WR1: write beyond := (beyond was GOAL ? BOX_GOAL : BOX).
- WR2: write target := (target was BOX_GOAL ? GOAL : FLOOR). Then accept.
- RESP: pulse exactly one of `accept_move[g]` / `reject_move[g]` for one cycle. On accept, drive `goto` = target. Then go to IDLE.
- A requester must drop `ask_move` in the cycle after its pulse. IDLE ignores channel g for one cycle after RESP, so a held request is not re-served.
- Coordinate arithmetic is XW+1 bits signed. Negative results are out of bounds; there is no wrap-around.

## Timing
- Reset values: all outputs 0, state IDLE, RR pointer at channel 0.
- Latency from `ask_move` rising to the response pulse:
  - geometry reject: 3 cycles (IDLE, ARB, RESP);
  - plain move or single-read reject: 5 cycles;
  - push rejected at EV2: 7 cycles;
  - accepted push: 9 cycles.
- Only one transaction is in flight. Other requesters wait, holding `ask_move`.
- `map_we` is high only in WR1 and WR2, one cycle each, so a push produces exactly two writes. No read and write target the same address in the same cycle.
- `map_raddr` holds its last value outside RD states. Reads have no side effects.
- An `ask_move` drop mid-transaction is ignored; the transaction completes and pulses anyway.
- Asserting `sys_rst` mid-push may leave the map with only the WR1 write. This is accepted; the map reloads on reset elsewhere.
- Simultaneous requests are served in round-robin order. With N_AGENTS continuously requesting, each is served within N_AGENTS transactions.

## Structure
- Package `grid_pkg`: tile code constants, the `is_passable`/`is_box` helper functions and the state encoding.
- Sub-module `rr_arbiter` (parameter N): request vector in, one-hot grant out, with a pointer that advances on grant. Used by ARB.
- Map RAM stays outside the block. The bench models it with a 1-cycle-read register file.

## Test plan
- Agent 0 at (2,2) on FLOOR map, requests (3,2) -> `accept_move[0]` 5 cycles later, goto=(3,2), no writes.
- Request (4,2) from (2,2) (non-adjacent) -> reject 3 cycles later, no map read.
- Tile (3,2)=WALL -> reject. Request (0,-1 wrapped) from (0,0) -> reject (out of bounds).
- BOX at (3,2), FLOOR at (4,2) -> accept after 9 cycles; writes (4,2)=BOX then (3,2)=FLOOR. With GOAL at (4,2), the first write is BOX_GOAL instead. With PUSH_EN=0 -> reject.
- BOX at (3,2), WALL at (4,2) -> reject at EV2 after 7 cycles, no `map_we`.
- Agents 0 and 1 request in the same cycle -> channel 0 is served first, then channel 1. Agent 1 moving onto agent 0's tile -> reject. Assert `sys_rst` during WR1 -> all outputs 0 asynchronously.
